// File: rtl/mac_inverse_div.sv
// rtl/mac_inverse_div.sv - recovers A and remainder from a MAC result D = A*B + C
// Multi-cycle restoring divider computing (D-C)/B with a start/busy/done handshake.
module mac_inverse_div #(
    parameter int Width = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2*Width-1:0] D_IN,
    input  logic [Width-1:0]   B4,
    input  logic [Width-1:0]   C4,
    output logic               busy,
    output logic               done,
    output logic [Width-1:0]   A_OUT,
    output logic [Width-1:0]   R_OUT,
    output logic [1:0]         err
);
    localparam int CW = (Width > 1) ? $clog2(Width) : 1;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_DIVZ = 2'd1;
    localparam logic [1:0] ERR_NEG  = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2*Width-1:0] d_r;
    logic [Width-1:0]   b_r;
    logic [Width-1:0]   c_r;
    logic [Width-1:0]   rem_r;
    logic [Width-1:0]   lo_r;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         err_r;

    logic [2*Width:0]   diff;
    logic [1:0]         sub_err;
    logic [Width:0]     trial;
    logic               trial_ge;
    logic [Width-1:0]   trial_sub;

    assign diff = {1'b0, d_r} - {{(Width+1){1'b0}}, c_r};

    always_comb begin
        sub_err = ERR_OK;
        if (b_r == '0)
            sub_err = ERR_DIVZ;
        else if (diff[2*Width])
            sub_err = ERR_NEG;
        else if (diff[2*Width-1:Width] >= b_r)
            sub_err = ERR_OVF;
    end

    // lo_r shifts dividend bits out at the top and quotient bits in at the bottom
    assign trial     = {rem_r, lo_r[Width-1]};
    assign trial_ge  = trial >= {1'b0, b_r};
    assign trial_sub = trial[Width-1:0] - b_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_SUB;
            S_SUB: begin
                busy      = 1'b1;
                state_nxt = (sub_err != ERR_OK) ? S_DONE : S_DIV;
            end
            S_DIV: begin
                busy = 1'b1;
                if (cnt_r == '0) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            rem_r <= '0;
            lo_r  <= '0;
            cnt_r <= '0;
            err_r <= ERR_OK;
            done  <= 1'b0;
            A_OUT <= '0;
            R_OUT <= '0;
            err   <= ERR_OK;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d_r <= D_IN;
                        b_r <= B4;
                        c_r <= C4;
                    end
                end
                S_SUB: begin
                    err_r <= sub_err;
                    cnt_r <= CW'(Width - 1);
                    if (sub_err != ERR_OK) begin
                        rem_r <= '0;
                        lo_r  <= '0;
                    end else begin
                        rem_r <= diff[2*Width-1:Width];
                        lo_r  <= diff[Width-1:0];
                    end
                end
                S_DIV: begin
                    rem_r <= trial_ge ? trial_sub : trial[Width-1:0];
                    lo_r  <= {lo_r[Width-2:0], trial_ge};
                    cnt_r <= cnt_r - 1'b1;
                end
                S_DONE: begin
                    A_OUT <= lo_r;
                    R_OUT <= rem_r;
                    err   <= err_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_inverse_div.sv
// tb/tb_mac_inverse_div.sv - scoreboard bench for mac_inverse_div
module tb_mac_inverse_div;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] D_IN = '0;
    logic [W-1:0]   B4 = '0;
    logic [W-1:0]   C4 = '0;
    logic           busy;
    logic           done;
    logic [W-1:0]   A_OUT;
    logic [W-1:0]   R_OUT;
    logic [1:0]     err;

    typedef struct {
        int unsigned a;
        int unsigned r;
        int unsigned e;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cnt = 0;

    mac_inverse_div #(.Width(W)) dut (
        .clk(clk), .reset(reset), .start(start), .D_IN(D_IN), .B4(B4), .C4(C4),
        .busy(busy), .done(done), .A_OUT(A_OUT), .R_OUT(R_OUT), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned d, input int unsigned b,
                                   input int unsigned c, input int start_cyc);
        exp_t x;
        int unsigned q;
        x.a = 0; x.r = 0; x.e = 0;
        if (b == 0)
            x.e = 1;
        else if (d < c)
            x.e = 2;
        else begin
            q = (d - c) / b;
            if (q > 255) x.e = 3;
            else begin
                x.a = q;
                x.r = (d - c) % b;
            end
        end
        x.cyc = start_cyc + ((x.e != 0) ? 2 : W + 2);
        return x;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t x;
            done_cnt++;
            if (sb.size() == 0)
                chk("unexpected_done", 1, 0);
            else begin
                x = sb.pop_front();
                chk("A_OUT", A_OUT, x.a);
                chk("R_OUT", R_OUT, x.r);
                chk("err", err, x.e);
                chk("done_cycle", cyc, x.cyc);
            end
        end
    end

    task automatic wait_dones(input int target);
        for (int i = 0; i < 40; i++) begin
            if (done_cnt >= target) return;
            @(posedge clk);
        end
        chk("done_timeout", done_cnt, target);
    endtask

    task automatic launch(input int unsigned d, input int unsigned b, input int unsigned c);
        @(posedge clk); #1;
        D_IN = d[2*W-1:0]; B4 = b[W-1:0]; C4 = c[W-1:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back(model(d, b, c, cyc));
        D_IN = 16'($urandom); B4 = 8'($urandom); C4 = 8'($urandom);
    endtask

    task automatic op(input int unsigned d, input int unsigned b, input int unsigned c);
        int n0;
        n0 = done_cnt;
        launch(d, b, c);
        wait_dones(n0 + 1);
    endtask

    initial begin
        int n0;
        int unsigned a, b, c;
        #1;
        chk("rst_A", A_OUT, 0);
        chk("rst_R", R_OUT, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        op(47, 7, 5);
        op(50, 7, 5);
        op(65280, 255, 255);
        op(0, 1, 0);
        op(1234, 0, 9);
        op(3, 7, 5);
        op(2000, 2, 0);
        op(65535, 255, 0);
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            c = $urandom_range(0, 255);
            op(a * b + c + $urandom_range(0, 3), b, c);
        end

        // extra start pulses at cycles 3 and 9 of a running op must be dropped
        n0 = done_cnt;
        launch(47, 7, 5);
        chk("busy_in_op", busy, 1);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_dones(n0 + 1);
        repeat (20) @(posedge clk);
        chk("one_done_only", done_cnt, n0 + 1);

        // reset mid-DIV aborts silently
        n0 = done_cnt;
        @(posedge clk); #1;
        D_IN = 16'd500; B4 = 8'd3; C4 = 8'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_A", A_OUT, 0);
        chk("midrst_R", R_OUT, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        chk("midrst_no_done", done_cnt, n0);
        op(1000, 9, 4);

        // start held high: back-to-back ops, one per W+3 cycles
        n0 = done_cnt;
        @(posedge clk); #1;
        D_IN = 16'd1000; B4 = 8'd13; C4 = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(1000, 13, 7, cyc));
        sb.push_back(model(1000, 13, 7, cyc + W + 3));
        repeat (W + 3) @(posedge clk);
        #1 start = 1'b0;
        wait_dones(n0 + 2);
        repeat (20) @(posedge clk);
        chk("held_start_dones", done_cnt, n0 + 2);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
